// File: rtl/peres_result_collector.sv
// Result collector after the Peres gate: selects/accumulates P/Q/R, flags the result, and buffers it in a 2-entry FIFO.
// Optional parity storage is enabled by defining PERES_COLLECTOR_PARITY_EN; otherwise out_parity is tied to 0.
module peres_result_collector #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] P,
  input  logic [WIDTH-1:0] Q,
  input  logic [WIDTH-1:0] R,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_op,
  output logic             out_zero,
  output logic             out_parity,
  output logic [WIDTH-1:0] acc_value,
  output logic [CNT_W-1:0] res_count
);

  logic [WIDTH-1:0] data_mem_r [2];
  logic [1:0]       op_mem_r   [2];
  logic             zero_mem_r [2];
  logic             wr_ptr_r;
  logic             rd_ptr_r;
  logic [1:0]       count_r;
  logic [WIDTH-1:0] acc_r;
  logic [CNT_W-1:0] cnt_r;
  // Last popped entry, shown on out_* while the FIFO is empty
  logic [WIDTH-1:0] last_data_r;
  logic [1:0]       last_op_r;
  logic             last_zero_r;

  logic             accept_s;
  logic             pop_s;
  logic [WIDTH-1:0] acc_base_s;
  logic [WIDTH-1:0] acc_next_s;
  logic [WIDTH-1:0] result_s;
  logic             result_zero_s;

  function automatic logic calc_zero(input logic [WIDTH-1:0] d);
    return (d == {WIDTH{1'b0}});
  endfunction

`ifdef PERES_COLLECTOR_PARITY_EN
  logic par_mem_r [2];
  logic last_par_r;
  logic result_par_s;

  function automatic logic calc_parity(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction
`endif

  // Readiness depends only on registered occupancy
  assign in_ready  = (count_r != 2'd2);
  assign out_valid = (count_r != 2'd0);

  // Handshakes, accumulator next value and the result to push
  always_comb begin
    accept_s   = in_valid && in_ready;
    pop_s      = out_valid && out_ready;
    acc_base_s = acc_clr ? {WIDTH{1'b0}} : acc_r;
    acc_next_s = acc_base_s ^ Q;
    result_s   = {WIDTH{1'b0}};
    case (op)
      2'b00:   result_s = P;
      2'b01:   result_s = Q;
      2'b10:   result_s = R;
      2'b11:   result_s = acc_next_s;
      default: result_s = {WIDTH{1'b0}};
    endcase
    result_zero_s = calc_zero(result_s);
  end

`ifdef PERES_COLLECTOR_PARITY_EN
  // Parity of the result being pushed
  always_comb begin
    result_par_s = calc_parity(result_s);
  end
`endif

  // FIFO storage written on accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        data_mem_r[i] <= {WIDTH{1'b0}};
        op_mem_r[i]   <= 2'b00;
        zero_mem_r[i] <= 1'b0;
      end
    end else if (accept_s) begin
      data_mem_r[wr_ptr_r] <= result_s;
      op_mem_r[wr_ptr_r]   <= op;
      zero_mem_r[wr_ptr_r] <= result_zero_s;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (accept_s) begin
        wr_ptr_r <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({accept_s, pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Capture the head on pop so outputs hold after the FIFO drains
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_data_r <= {WIDTH{1'b0}};
      last_op_r   <= 2'b00;
      last_zero_r <= 1'b0;
    end else if (pop_s) begin
      last_data_r <= data_mem_r[rd_ptr_r];
      last_op_r   <= op_mem_r[rd_ptr_r];
      last_zero_r <= zero_mem_r[rd_ptr_r];
    end
  end

`ifdef PERES_COLLECTOR_PARITY_EN
  // Parity storage alongside each entry and the held head
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_mem_r[0] <= 1'b0;
      par_mem_r[1] <= 1'b0;
      last_par_r   <= 1'b0;
    end else begin
      if (accept_s) begin
        par_mem_r[wr_ptr_r] <= result_par_s;
      end
      if (pop_s) begin
        last_par_r <= par_mem_r[rd_ptr_r];
      end
    end
  end
`endif

  // Accumulator: an accepted op 11 wins over a standalone clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r <= {WIDTH{1'b0}};
    end else if (accept_s && (op == 2'b11)) begin
      acc_r <= acc_next_s;
    end else if (acc_clr) begin
      acc_r <= {WIDTH{1'b0}};
    end
  end

  // Accepted-result counter, wraps naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign acc_value = acc_r;
  assign res_count = cnt_r;

  // Head entry when occupied, else the last popped entry
  always_comb begin
    if (count_r != 2'd0) begin
      out_data = data_mem_r[rd_ptr_r];
      out_op   = op_mem_r[rd_ptr_r];
      out_zero = zero_mem_r[rd_ptr_r];
    end else begin
      out_data = last_data_r;
      out_op   = last_op_r;
      out_zero = last_zero_r;
    end
  end

`ifdef PERES_COLLECTOR_PARITY_EN
  // Parity of the presented entry
  always_comb begin
    if (count_r != 2'd0) begin
      out_parity = par_mem_r[rd_ptr_r];
    end else begin
      out_parity = last_par_r;
    end
  end
`else
  assign out_parity = 1'b0;
`endif

endmodule

// File: doc/peres_result_collector.md
# peres_result_collector

Downstream stage of the modified Peres gate in the reversible-logic ALU. Each cycle it can accept one P/Q/R output triple plus an opcode. It selects or accumulates the requested result and computes status flags. Results are held in a 2-entry output FIFO with a valid/ready handshake, so the ALU back-end can stall without losing Peres outputs.

## Interface
- WIDTH, 32, datapath width; matches the Peres stage P/Q/R width
- CNT_W, 16, width of the accepted-result counter
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  P/Q/R/op are valid this cycle
- in_ready  output  1  collector can accept this cycle
- op  input  2  00=pass P, 01=pass Q, 10=pass R, 11=XOR-accumulate Q
- P, Q, R  input  WIDTH each  Peres gate outputs
- acc_clr  input  1  synchronous clear of the accumulator
- out_valid  output  1  FIFO head is valid
- out_ready  input  1  consumer takes head this cycle
- out_data  output  WIDTH  selected/accumulated result at FIFO head
- out_op  output  2  opcode that produced the head entry
- out_zero  output  1  head result == 0
- out_parity  output  1  XOR-reduction of head result (see Configuration)
- acc_value  output  WIDTH  current accumulator register
- res_count  output  CNT_W  number of accepted inputs, wraps modulo 2^CNT_W

## Operation
- Accept occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- Result on accept, by op:
  - op 00: result = P
  - op 01: result = Q
  - op 10: result = R
  - op 11: acc_next = acc_base ^ Q; result = acc_next; the accumulator register loads acc_next
- acc_base is 0 if acc_clr is asserted in the same cycle, otherwise the accumulator register.
- acc_clr without an accepted op 11: accumulator <= 0. Ops 00/10/01 never modify the accumulator.
- Pushed entry = {result, op, zero, parity}; flags are computed from result at push time.
- FIFO:
  - 2 entries, write/read pointers, occupancy count 0..2.
  - in_ready = (count != 2); it depends only on registered state, with no combinational path from out_ready.
  - out_valid = (count != 0); out_* are driven from the head entry.
- Full (count 2): no accept, even if a pop occurs the same cycle. The pop still happens and count becomes 1.
- Empty (count 0): out_valid = 0; out_data/out_op/out_zero/out_parity hold the last popped values (0 after reset).
- Simultaneous push and pop at count 1: count stays 1, and the new entry becomes head next cycle.
- res_count increments by 1 on every accept and wraps 0xFFFF -> 0x0000 (CNT_W=16).
- Reset (asynchronous, any time, including mid-handshake): FIFO emptied, pointers 0, accumulator 0, res_count 0, all out_* 0. in_ready goes to 1 and out_valid to 0 immediately. Entries in flight are discarded.

## Timing
- Latency: accept in cycle N -> out_valid=1 with that entry in cycle N+1, provided the FIFO was empty or only the head is popped.
- Throughput: 1 result/cycle when out_ready is held high.
- in_valid/op/P/Q/R are sampled only on accept. The producer holds them while in_ready=0.
- out_* are stable while out_valid=1 and out_ready=0.
- acc_value updates on the clock edge after an accepted op 11 or an acc_clr.
- Reset values: in_ready=1, out_valid=0, out_data=0, out_op=0, out_zero=0, out_parity=0, acc_value=0, res_count=0.

## Configuration
- Macro: PERES_COLLECTOR_PARITY_EN.
- Defined: parity bit stored per FIFO entry; out_parity = ^result of the head entry.
- Undefined: no parity storage or logic; out_parity tied to 0. The port remains so the interface is unchanged.

## Test plan
- **Basic pass-through.**
  - Stimulus: reset, then one accept with op=01, P=A5A5A5A5, Q=FFFFFFFF, R=00000000; out_ready=1.
  - Response: next cycle out_valid=1, out_data=FFFFFFFF, out_op=01, out_zero=0, out_parity=0.
  - Then out_valid=0; res_count=1.
- **Zero flag and R select.**
  - Stimulus: accept op=10, R=00000000.
  - Response: out_data=0, out_zero=1.
  - Then accept op=00, P=12345678.
  - Response: out_data=12345678, out_zero=0, out_parity=1 (parity enabled).
- **Accumulate.**
  - Stimulus: op=11 with Q=0F0F0F0F, then op=11 with Q=F0F0F0F0.
  - Response: outputs 0F0F0F0F, then FFFFFFFF; acc_value=FFFFFFFF.
  - Then acc_clr together with op=11, Q=AAAAAAAA.
  - Response: output AAAAAAAA; acc_value=AAAAAAAA.
- **Backpressure.**
  - Stimulus: out_ready=0, in_valid=1 for 3 cycles, op=00, P=1,2,3.
  - Response: accepts P=1 and P=2; in_ready=0 on cycle 3.
  - Then out_ready=1 for 1 cycle.
  - Response: pops 1; no accept in that cycle; in_ready=1 next cycle; P=3 is accepted after that.
  - Order out: 1, 2, 3.
- **Reset mid-operation.**
  - Stimulus: FIFO holds 2 entries and acc=FFFFFFFF; assert rst between clock edges.
  - Response: out_valid=0, in_ready=1, acc_value=0, res_count=0 immediately, without waiting for a clock edge.
- **Counter wrap.**
  - Stimulus: 65536 accepts with out_ready=1.
  - Response: res_count returns to 0000.
